// File: rtl/btn_pkg.sv
// Shared constants and helpers for the pushbutton conditioner.
package btn_pkg;

   localparam int unsigned PIO_WORD_W   = 32;
   localparam int unsigned LATCH_OFFSET = 16;
   localparam int unsigned MAX_BTN      = 16;

   // Width of a counter that must hold 0 .. cycles-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce_bit.sv
// One button: 2-flop synchronizer, polarity normalization and counter debouncer.
module btn_debounce_bit
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned ACTIVE_LOW      = 1
) (
   input  logic clk_clk,
   input  logic reset_reset,
   input  logic btn_raw_i,
   output logic level_o
);

   localparam int unsigned     CntW     = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntMax   = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic            Released = (ACTIVE_LOW != 0);

   logic            sync1_q, sync2_q;
   logic            pressed;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            level_q, level_d;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         sync1_q <= Released;
         sync2_q <= Released;
      end else begin
         sync1_q <= btn_raw_i;
         sync2_q <= sync1_q;
      end
   end

   assign pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

   // Compare before increment so the counter tops out at DEBOUNCE_CYCLES-1.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (pressed != level_q) begin
         if (cnt_q == CntMax) begin
            level_d = pressed;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces NUM_BTN pushbuttons and packs them into the 32-bit PIO word.
// Define BTN_PRESS_LATCH_EN to build the sticky per-button press latch.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int unsigned NUM_BTN         = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned ACTIVE_LOW      = 1
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset,
   input  logic [NUM_BTN-1:0]    btn_raw_i,
   input  logic [NUM_BTN-1:0]    press_clr_i,
   output logic [NUM_BTN-1:0]    btn_level_o,
   output logic [NUM_BTN-1:0]    btn_press_o,
   output logic [PIO_WORD_W-1:0] pio_word_o
);

   logic [NUM_BTN-1:0]    level_prev_q;
   logic [NUM_BTN-1:0]    latch_field;
   logic [PIO_WORD_W-1:0] pio_q, pio_d;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_debounce (
         .clk_clk    (clk_clk),
         .reset_reset(reset_reset),
         .btn_raw_i  (btn_raw_i[i]),
         .level_o    (btn_level_o[i])
      );
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         level_prev_q <= '0;
      end else begin
         level_prev_q <= btn_level_o;
      end
   end

   // Combinational so the pulse coincides with the rising debounced level.
   assign btn_press_o = btn_level_o & ~level_prev_q;

`ifdef BTN_PRESS_LATCH_EN
   logic [NUM_BTN-1:0] latch_q, latch_d;

   // Set wins over clear so a press arriving with a clear is never lost.
   assign latch_d = btn_press_o | (latch_q & ~press_clr_i);

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         latch_q <= '0;
      end else begin
         latch_q <= latch_d;
      end
   end

   assign latch_field = latch_d;
`else
   logic unused_press_clr;
   assign unused_press_clr = ^press_clr_i;
   assign latch_field      = '0;
`endif

   always_comb begin
      pio_d                          = '0;
      pio_d[NUM_BTN-1:0]             = btn_level_o;
      pio_d[LATCH_OFFSET +: NUM_BTN] = latch_field;
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         pio_q <= '0;
      end else begin
         pio_q <= pio_d;
      end
   end

   assign pio_word_o = pio_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner against a sliding-window reference model.
module tb_button_conditioner;

   localparam int unsigned NB = 4;
   localparam int unsigned DB = 8;

   logic          clk_clk = 1'b0;
   logic          reset_reset = 1'b1;
   logic [NB-1:0] btn_raw = '1;
   logic [NB-1:0] press_clr = '0;
   logic [NB-1:0] level, press;
   logic [31:0]   pio;

   button_conditioner #(
      .NUM_BTN        (NB),
      .DEBOUNCE_CYCLES(DB),
      .ACTIVE_LOW     (1)
   ) dut (
      .clk_clk    (clk_clk),
      .reset_reset(reset_reset),
      .btn_raw_i  (btn_raw),
      .press_clr_i(press_clr),
      .btn_level_o(level),
      .btn_press_o(press),
      .pio_word_o (pio)
   );

   always #5 clk_clk = ~clk_clk;

   typedef struct packed {
      logic [NB-1:0] level;
      logic [NB-1:0] press;
      logic [31:0]   pio;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Reference model: pressed samples per edge, newest at the back.
   logic [NB-1:0] hist[$];
   logic [NB-1:0] m_level, m_press, m_latch;
   logic [31:0]   m_pio;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < int'(DB) + 2; i++) hist.push_back('0);
      m_level = '0;
      m_press = '0;
      m_latch = '0;
      m_pio   = '0;
   endtask

   // A level flips when the DB samples that have crossed the synchronizer all disagree with it.
   task automatic model_edge(input logic [NB-1:0] raw, input logic [NB-1:0] clr);
      logic [NB-1:0] pressed_now;
      logic [NB-1:0] new_level;
      logic [NB-1:0] new_latch;
      logic [NB-1:0] sample;
      logic [31:0]   new_pio;
      bit            flip;
      pressed_now = ~raw;
      new_level   = m_level;
      for (int b = 0; b < int'(NB); b++) begin
         flip = 1'b1;
         for (int k = 0; k < int'(DB); k++) begin
            sample = hist[hist.size() - 2 - k];
            if (sample[b] == m_level[b]) flip = 1'b0;
         end
         if (flip) new_level[b] = ~m_level[b];
      end
`ifdef BTN_PRESS_LATCH_EN
      new_latch = m_press | (m_latch & ~clr);
`else
      new_latch = '0;
      if (clr != clr) new_latch = '1;
`endif
      new_pio          = '0;
      new_pio[NB-1:0]  = m_level;
      new_pio[16 +: NB] = new_latch;
      m_press = new_level & ~m_level;
      m_level = new_level;
      m_latch = new_latch;
      m_pio   = new_pio;
      hist.push_back(pressed_now);
      if (hist.size() > DB + 2) void'(hist.pop_front());
      exp_q.push_back('{level: m_level, press: m_press, pio: m_pio});
   endtask

   task automatic cycle(input logic [NB-1:0] raw, input logic [NB-1:0] clr);
      #1;
      btn_raw   = raw;
      press_clr = clr;
      @(posedge clk_clk);
      model_edge(raw, clr);
   endtask

   task automatic mid_reset(input int n);
      @(negedge clk_clk);
      #1;
      reset_reset = 1'b1;
      #1;
      check("async_rst_level", 32'(level), 32'h0);
      check("async_rst_press", 32'(press), 32'h0);
      check("async_rst_pio", pio, 32'h0);
      model_reset();
      repeat (n) begin
         @(posedge clk_clk);
         exp_q.push_back('{level: '0, press: '0, pio: '0});
      end
      #1;
      reset_reset = 1'b0;
   endtask

   always @(negedge clk_clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("level", 32'(level), 32'(mon_e.level));
         check("press", 32'(press), 32'(mon_e.press));
         check("pio", pio, mon_e.pio);
      end
   end

   initial begin
      logic [NB-1:0] raw;
      logic [NB-1:0] clr;
      model_reset();
      repeat (3) @(posedge clk_clk);
      #1;
      check("reset_level", 32'(level), 32'h0);
      check("reset_press", 32'(press), 32'h0);
      check("reset_pio", pio, 32'h0);
      reset_reset = 1'b0;

      repeat (5) cycle(4'hF, 4'h0);
      repeat (14) cycle(4'hE, 4'h0);
      repeat (4) begin
         repeat (5) cycle(4'hC, 4'h0);
         cycle(4'hE, 4'h0);
      end
      repeat (12) cycle(4'hF, 4'h0);

      repeat (12) cycle(4'hB, 4'h0);
      repeat (12) cycle(4'hF, 4'h0);
      cycle(4'hF, 4'h4);
      repeat (3) cycle(4'hF, 4'h0);
      // Raise the clear exactly while the model expects the bit-2 press pulse.
      repeat (14) cycle(4'hB, m_press & 4'h4);
      repeat (6) cycle(4'hF, 4'h0);

      raw = 4'hF;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(4, 0) == 0) raw[$urandom_range(NB - 1, 0)] ^= 1'b1;
         clr = ($urandom_range(7, 0) == 0) ? NB'($urandom) : '0;
         cycle(raw, clr);
      end

      repeat (12) cycle(4'hF, 4'h0);
      repeat (7) cycle(4'h7, 4'h0);
      mid_reset(2);
      repeat (14) cycle(4'h7, 4'h0);
      repeat (4) cycle(4'hF, 4'h0);

      @(negedge clk_clk);
      @(negedge clk_clk);
      #1;
      check("drain", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
